fdct4_stage: RTL and testbench



---
 rtl/fdct_pkg.sv | 9 +
 rtl/fdct4_stage_if.sv | 24 ++
 rtl/fdct4_core.sv | 79 +++++++
 rtl/fdct4_stage.sv | 76 +++++++
 tb/tb_fdct4_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fdct_pkg.sv
// Shared constants for the 4-point forward DCT stage: HEVC coefficients and default widths.
package fdct_pkg;
    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 25;
    localparam int IDX_W     = 2;
    localparam int C64       = 64;
    localparam int C83       = 83;
    localparam int C36       = 36;
endpackage

// File: rtl/fdct4_stage_if.sv
// Sample-in / coefficient-out bundle of the forward DCT stage.
interface fdct4_stage_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 25
) ();
    logic             in_valid;
    logic             in_first;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic [ACC_W-1:0] out_y0;
    logic [ACC_W-1:0] out_y1;
    logic [ACC_W-1:0] out_y2;
    logic [ACC_W-1:0] out_y3;
    logic             err;

    modport master (
        output in_valid, in_first, in_data,
        input  out_valid, out_y0, out_y1, out_y2, out_y3, err
    );
    modport slave (
        input  in_valid, in_first, in_data,
        output out_valid, out_y0, out_y1, out_y2, out_y3, err
    );
endinterface

// File: rtl/fdct4_core.sv
// Three-stage 4-point forward DCT datapath: butterfly, product sums, round/shift.
module fdct4_core
    import fdct_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = 7,
    parameter int ADD   = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vld_i,
    input  logic [3:0][IN_W-1:0]       x_i,
    output logic                       vld_o,
    output logic [3:0][ACC_W-1:0]      y_o
);
    localparam logic signed [ACC_W-1:0] K64  = ACC_W'(C64);
    localparam logic signed [ACC_W-1:0] K83  = ACC_W'(C83);
    localparam logic signed [ACC_W-1:0] K36  = ACC_W'(C36);
    localparam logic signed [ACC_W-1:0] KADD = ACC_W'(ADD);

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [IN_W-1:0] v);
        return ACC_W'(v);
    endfunction

    logic [2:0]                    vld_pipe_q;
    logic signed [ACC_W-1:0]       e0_q, e1_q, o0_q, o1_q;
    logic [3:0][ACC_W-1:0]         r_q;
    logic [3:0][ACC_W-1:0]         y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], vld_i};
        end
    end

    // Data registers only load on a valid tag so idle cycles leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0_q <= '0;
            e1_q <= '0;
            o0_q <= '0;
            o1_q <= '0;
        end else if (vld_i) begin
            e0_q <= sx(x_i[0]) + sx(x_i[3]);
            e1_q <= sx(x_i[1]) + sx(x_i[2]);
            o0_q <= sx(x_i[0]) - sx(x_i[3]);
            o1_q <= sx(x_i[1]) - sx(x_i[2]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (vld_pipe_q[0]) begin
            r_q[0] <= K64 * e0_q + K64 * e1_q;
            r_q[1] <= K83 * o0_q + K36 * o1_q;
            r_q[2] <= K64 * e0_q - K64 * e1_q;
            r_q[3] <= K36 * o0_q - K83 * o1_q;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_round
        logic signed [ACC_W-1:0] rnd;
        assign rnd = $signed(r_q[k]) + KADD;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                y_q[k] <= '0;
            end else if (vld_pipe_q[1]) begin
                y_q[k] <= rnd >>> SHIFT;
            end
        end
    end

    assign vld_o = vld_pipe_q[2];
    assign y_o   = y_q;
endmodule

// File: rtl/fdct4_stage.sv
// Serial-to-block collector with framing checks in front of the 4-point forward DCT core.
module fdct4_stage
    import fdct_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = 7,
    parameter int ADD   = 64
) (
    input  logic       clk,
    input  logic       reset,
    fdct4_stage_if.slave bus
);
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0][IN_W-1:0]   x_q, x_d;
    logic                   s0_valid_q, s0_valid_d;
    logic                   err_q, err_d;
    logic [3:0][ACC_W-1:0]  y;
    logic                   y_vld;

    always_comb begin
        idx_d      = idx_q;
        x_d        = x_q;
        s0_valid_d = 1'b0;
        err_d      = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_first) begin
                // A restart abandons any partial block.
                x_d[0] = bus.in_data;
                idx_d  = IDX_W'(1);
                err_d  = (idx_q != '0);
            end else if (idx_q == '0) begin
                err_d = 1'b1;
            end else begin
                x_d[idx_q] = bus.in_data;
                idx_d      = idx_q + 1'b1;
                s0_valid_d = (idx_q == IDX_W'(3));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            x_q        <= '0;
            s0_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            x_q        <= x_d;
            s0_valid_q <= s0_valid_d;
            err_q      <= err_d;
        end
    end

    fdct4_core #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .ADD   (ADD)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .vld_i (s0_valid_q),
        .x_i   (x_q),
        .vld_o (y_vld),
        .y_o   (y)
    );

    assign bus.out_valid = y_vld;
    assign bus.out_y0    = y[0];
    assign bus.out_y1    = y[1];
    assign bus.out_y2    = y[2];
    assign bus.out_y3    = y[3];
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fdct4_stage.sv
// Scoreboard bench for fdct4_stage: a driver pushes expected blocks/err pulses, a monitor pops and checks.
module tb_fdct4_stage;
    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    fdct4_stage_if #(.IN_W(16), .ACC_W(25)) bus ();

    fdct4_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int y[4];
    } exp_t;

    exp_t eq[$];
    int   errq[$];
    int   blk[$];
    int   last_y[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: DCT matrix product, then round-to-nearest via real floor.
    function automatic exp_t ref_block(input int c, input int x0, input int x1, input int x2, input int x3);
        exp_t e;
        int   r[4];
        r[0] = 64 * x0 + 64 * x1 + 64 * x2 + 64 * x3;
        r[1] = 83 * x0 + 36 * x1 - 36 * x2 - 83 * x3;
        r[2] = 64 * x0 - 64 * x1 - 64 * x2 + 64 * x3;
        r[3] = 36 * x0 - 83 * x1 + 83 * x2 - 36 * x3;
        e.cyc = c;
        for (int k = 0; k < 4; k++) e.y[k] = int'($floor((r[k] + 64) / 128.0));
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_first = 1'($urandom);
            bus.in_data  = 16'($urandom);
        end
    endtask

    task automatic send(input bit f, input int d, input int gap_max);
        int a;
        idle($urandom_range(0, gap_max));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_data  = 16'(d);
        a = cyc + 1;
        if (f) begin
            if (blk.size() != 0) errq.push_back(a);
            blk.delete();
            blk.push_back(d);
        end else if (blk.size() == 0) begin
            errq.push_back(a);
        end else begin
            blk.push_back(d);
            if (blk.size() == 4) begin
                eq.push_back(ref_block(a + 3, blk[0], blk[1], blk[2], blk[3]));
                blk.delete();
            end
        end
    endtask

    task automatic send_blk(input int x0, input int x1, input int x2, input int x3, input int gap_max);
        send(1'b1, x0, gap_max);
        send(1'b0, x1, gap_max);
        send(1'b0, x2, gap_max);
        send(1'b0, x3, gap_max);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        eq.delete();
        errq.delete();
        blk.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        int   yv[4];
        exp_t e;
        yv[0] = $signed(bus.out_y0);
        yv[1] = $signed(bus.out_y1);
        yv[2] = $signed(bus.out_y2);
        yv[3] = $signed(bus.out_y3);
        if (reset) begin
            chk("reset_outputs_zero",
                int'(bus.out_valid) + int'(bus.err) + (yv[0] != 0) + (yv[1] != 0) + (yv[2] != 0) + (yv[3] != 0), 0);
            for (int k = 0; k < 4; k++) last_y[k] = 0;
        end else begin
            if (bus.out_valid) begin
                if (eq.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = eq.pop_front();
                    chk("out_valid_latency", cyc, e.cyc);
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("y%0d", k), yv[k], e.y[k]);
                        last_y[k] = yv[k];
                    end
                end
            end else begin
                chk("y_hold",
                    (yv[0] != last_y[0]) + (yv[1] != last_y[1]) + (yv[2] != last_y[2]) + (yv[3] != last_y[3]), 0);
            end
            if (eq.size() != 0 && eq[0].cyc < cyc) begin
                chk("missing_out_valid", cyc, eq[0].cyc);
                void'(eq.pop_front());
            end
            if (bus.err) begin
                if (errq.size() == 0) chk("spurious_err", 1, 0);
                else chk("err_cycle", cyc, errq.pop_front());
            end
            if (errq.size() != 0 && errq[0] < cyc) begin
                chk("missing_err", cyc, errq[0]);
                void'(errq.pop_front());
            end
        end
    end

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        cyc          = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        send_blk(1, 1, 1, 1, 0);
        idle(6);
        send_blk(100, 0, 0, 0, 0);
        send_blk(-100, 0, 0, 0, 0);
        idle(5);
        send_blk(32767, 32767, 32767, 32767, 0);
        send_blk(32767, -32768, -32768, 32767, 0);
        idle(5);

        // Restart mid-block, then an unframed sample.
        send(1'b1, 7, 0);
        send(1'b0, 8, 0);
        send_blk(5, 5, 5, 5, 0);
        idle(5);
        send(1'b0, 9, 0);
        idle(5);

        send_blk(1, 1, 1, 1, 0);
        send_blk(100, 0, 0, 0, 0);
        send_blk(int'($urandom_range(0, 65535)) - 32768, -7, 123, int'($urandom_range(0, 65535)) - 32768, 3);
        idle(6);

        // Reset after x2, then reset with a block in the product stage.
        send(1'b1, 11, 0);
        send(1'b0, 12, 0);
        send(1'b0, 13, 0);
        do_reset();
        send_blk(300, -200, 100, 50, 0);
        idle(1);
        do_reset();
        idle(5);
        send_blk(-1, 2, -3, 4, 0);
        idle(5);

        for (int b = 0; b < 30; b++) begin
            if ($urandom_range(0, 7) == 0) send(1'($urandom), int'($urandom_range(0, 65535)) - 32768, 2);
            send_blk(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                     $urandom_range(0, 1) ? 0 : 2);
        end
        idle(8);
        chk("drain_out_queue", eq.size(), 0);
        chk("drain_err_queue", errq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
